// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG TAP state codes, scan op codes and instruction codes
package jtag_pkg;

    // IEEE 1149.1 TAP controller states
    localparam logic [3:0] TLR        = 4'd0;
    localparam logic [3:0] RTI        = 4'd1;
    localparam logic [3:0] SELECT_DR  = 4'd2;
    localparam logic [3:0] CAPTURE_DR = 4'd3;
    localparam logic [3:0] SHIFT_DR   = 4'd4;
    localparam logic [3:0] EXIT1_DR   = 4'd5;
    localparam logic [3:0] PAUSE_DR   = 4'd6;
    localparam logic [3:0] EXIT2_DR   = 4'd7;
    localparam logic [3:0] UPDATE_DR  = 4'd8;
    localparam logic [3:0] SELECT_IR  = 4'd9;
    localparam logic [3:0] CAPTURE_IR = 4'd10;
    localparam logic [3:0] SHIFT_IR   = 4'd11;
    localparam logic [3:0] EXIT1_IR   = 4'd12;
    localparam logic [3:0] PAUSE_IR   = 4'd13;
    localparam logic [3:0] EXIT2_IR   = 4'd14;
    localparam logic [3:0] UPDATE_IR  = 4'd15;

    // scan command op codes
    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // die instruction codes
    localparam logic [3:0] EXTEST = 4'h0;

    // scan master sequencing states
    typedef enum logic [2:0] {
        CTL_INIT,
        CTL_IDLE,
        CTL_WALK_IN,
        CTL_SHIFT,
        CTL_WALK_OUT,
        CTL_RST_SEQ
    } ctl_state_t;

endpackage

// File: rtl/jtag_tap_mirror.sv
// rtl/jtag_tap_mirror.sv - IEEE 1149.1 TAP state register and next-state function
module jtag_tap_mirror
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       tms,
    output logic [3:0] tap_state
);

    logic [3:0] tap_next;

    // 16-state TAP transition selected by the TMS value sampled on this edge
    always_comb begin
        tap_next = TLR;
        case (tap_state)
            TLR:        tap_next = tms ? TLR       : RTI;
            RTI:        tap_next = tms ? SELECT_DR : RTI;
            SELECT_DR:  tap_next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: tap_next = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   tap_next = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   tap_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   tap_next = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   tap_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  tap_next = tms ? SELECT_DR : RTI;
            SELECT_IR:  tap_next = tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: tap_next = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   tap_next = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   tap_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   tap_next = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   tap_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  tap_next = tms ? SELECT_DR : RTI;
            default:    tap_next = TLR;
        endcase
    end

    // state register; TRST forces Test-Logic-Reset just like the target
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            tap_state <= TLR;
        end else begin
            tap_state <= tap_next;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator sequencing TAP reset, IR and DR scans
module jtag_scan_master
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state,
    output logic               busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    ctl_state_t         state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [LEN_W-1:0]   cnt_inc;
    logic [LEN_W-1:0]   walk_last;
    logic [LEN_W-1:0]   len_clamped;
    logic               is_ir, is_ir_nxt;
    logic               tms_nxt;
    logic               rsp_valid_nxt;
    logic [MAX_LEN-1:0] rsp_data_nxt;
    logic [MAX_LEN-1:0] sh;
    logic               accept;
    logic               shift_edge;

    jtag_tap_mirror u_mirror (
        .TCK       (TCK),
        .TRST      (TRST),
        .tms       (tms),
        .tap_state (tap_state)
    );

    assign len_clamped = (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
    assign cmd_ready   = (state == CTL_IDLE) && (tap_state == RTI);
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = !((state == CTL_IDLE) || (state == CTL_INIT));
    assign shift_edge  = (tap_state == SHIFT_DR) || (tap_state == SHIFT_IR);
    assign tdi         = sh[0];
    assign cnt_inc     = cnt + LEN_W'(1);
    // IR path goes through SELECT_IR, so it has one more walk-in edge
    assign walk_last   = is_ir ? LEN_W'(3) : LEN_W'(2);

    // tms_nxt is the TMS level the target will sample on the following edge
    always_comb begin
        state_nxt     = state;
        tms_nxt       = tms;
        cnt_nxt       = cnt;
        len_nxt       = len;
        is_ir_nxt     = is_ir;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        case (state)
            CTL_INIT: begin
                state_nxt = CTL_IDLE;
                tms_nxt   = 1'b0;
            end
            CTL_IDLE: begin
                if (accept) begin
                    len_nxt   = len_clamped;
                    cnt_nxt   = '0;
                    is_ir_nxt = (cmd_op == OP_IR);
                    if ((cmd_op == OP_RSVD) || (cmd_len == '0)) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = '0;
                    end else if (cmd_op == OP_RESET) begin
                        state_nxt = CTL_RST_SEQ;
                        tms_nxt   = 1'b1;
                    end else begin
                        state_nxt = CTL_WALK_IN;
                        tms_nxt   = 1'b1;
                    end
                end
            end
            CTL_WALK_IN: begin
                cnt_nxt = cnt_inc;
                if (cnt == walk_last) begin
                    // entering SHIFT now; a one-bit scan exits on its first shift
                    state_nxt = CTL_SHIFT;
                    cnt_nxt   = '0;
                    tms_nxt   = (len == LEN_W'(1));
                end else begin
                    tms_nxt = is_ir && (cnt == '0);
                end
            end
            CTL_SHIFT: begin
                if (cnt_inc == len) begin
                    state_nxt = CTL_WALK_OUT;
                    cnt_nxt   = '0;
                    tms_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                    tms_nxt = ((cnt + LEN_W'(2)) == len);
                end
            end
            CTL_WALK_OUT: begin
                if (cnt == '0) begin
                    cnt_nxt = LEN_W'(1);
                    tms_nxt = 1'b0;
                end else begin
                    state_nxt     = CTL_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = sh >> (MAX_LEN_L - len);
                end
            end
            CTL_RST_SEQ: begin
                cnt_nxt = cnt_inc;
                if (cnt < LEN_W'(4)) begin
                    tms_nxt = 1'b1;
                end else if (cnt == LEN_W'(4)) begin
                    tms_nxt = 1'b0;
                end else begin
                    state_nxt     = CTL_IDLE;
                    tms_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = '0;
                end
            end
            default: begin
                state_nxt = CTL_INIT;
                tms_nxt   = 1'b0;
            end
        endcase
    end

    // controller registers; TRST aborts any command without a response
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state     <= CTL_INIT;
            tms       <= 1'b0;
            cnt       <= '0;
            len       <= '0;
            is_ir     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            tms       <= tms_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            is_ir     <= is_ir_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    // shift register: loaded on accept, TDO enters at the top on every shift edge
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            sh <= '0;
        end else if (accept) begin
            sh <= cmd_data;
        end else if (shift_edge) begin
            sh <= {tdo, sh[MAX_LEN-1:1]};
        end
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- JTAG initiator that drives TMS/TDI into a die TAP and wrapper register chain, and collects TDO.
- Accepts one command at a time (TAP reset, IR scan or DR scan of up to MAX_LEN bits) and walks the TAP state machine.
- Shifts the command data in LSB-first and returns the captured bits.
- Sits on the test-controller side of the die chain and keeps a cycle-exact mirror of the target tap_state.

Parameters:
- MAX_LEN, 32, maximum scan length in bits.
- LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- TCK  in  1  test clock; all state changes on posedge.
- TRST  in  1  asynchronous active-high reset; tie to the inverse of the target TRST_N.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master can accept a command this cycle.
- cmd_op  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=reserved.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  MAX_LEN  TDI bits; bit 0 is shifted first.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, right-justified; bit 0 is the first bit captured.
- tms  out  1  registered TMS to the target.
- tdi  out  1  TDI to the target; equals shift-register bit 0.
- tdo  in  1  TDO from the target chain.
- tap_state  out  4  mirrored target TAP state.
- busy  out  1  command in progress.

Behaviour:
- State encoding: TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SHIFT_DR=4, EX1_DR=5, PAUSE_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SHIFT_IR=11, EX1_IR=12, PAUSE_IR=13, EX2_IR=14, UPD_IR=15.
- Mirror: tap_state updates every posedge from the current tms using the IEEE 1149.1 next-state function, so it always equals the target's state.
- Reset (TRST=1): tap_state=TLR, tms=0, shift register=0, rsp_data=0, rsp_valid=0, busy=0, cmd_ready=0, controller state=INIT.
  - The first edge after release moves the TAP to RTI.
  - cmd_ready=1 from the following cycle.
- cmd_ready = controller IDLE and tap_state==RTI. Accept on posedge when cmd_valid && cmd_ready.
- On accept: shift register <= cmd_data; len <= min(cmd_len, MAX_LEN). cmd_valid while not ready is ignored; no queueing.
- Controller states: INIT, IDLE, WALK_IN, SHIFT, WALK_OUT, RST_SEQ. The TMS sequence each state drives is below; accept edge = k.
- DR scan TMS, per edge:
  - edges k+1..k+3: 1,0,0, giving SEL_DR, CAP_DR, SHIFT_DR.
  - N shift edges k+4..k+3+N: tms=0 except the last edge, tms=1.
  - EX1_DR -> UPD_DR (tms=1), then UPD_DR -> RTI (tms=0).
  - rsp_valid pulses in the cycle after edge k+N+5.
- IR scan: same flow with an extra leading 1 (1,1,0,0 into SHIFT_IR); rsp_valid after edge k+N+6.
- Each shift edge (tap_state SHIFT_DR or SHIFT_IR): sh <= {tdo, sh[MAX_LEN-1:1]}. tdi = sh[0] throughout.
- rsp_data = sh >> (MAX_LEN-N), registered on the last WALK_OUT edge, and held until the next completion.
- TAP reset op: tms=1 for 5 edges (k+1..k+5), tms=0 at k+6 giving RTI; rsp_valid after k+6; rsp_data=0.
- len=0 or op=3:
  - No TAP activity; tms stays 0 and the TAP stays in RTI.
  - rsp_valid pulses the cycle after accept with rsp_data=0.
- Back-to-back: cmd_ready is high in the rsp_valid cycle, so a new command may be accepted on that edge.
- busy = controller not in IDLE/INIT.
- TRST mid-command: immediate abort, all values return to the reset values above; no rsp_valid.

Decomposition:
- Package jtag_pkg: the 16 TAP state localparams (SHIFT_DR=4, CAPTURE_DR=3, UPDATE_DR=8, ...), op codes, and the EXTEST=4'h0 instruction code.
- Sub-module jtag_tap_mirror: combinational 16-state next-state function plus the state register. Shared with the target-side TAP controller.

Test Plan:
- Reset then idle: assert/release TRST -> tap_state TLR then RTI, cmd_ready=1 two cycles after release, tms=0.
- DR scan against a die wrapper register (IR=EXTEST, func_in=0x3C), op=2, len=8, data=0xA5 -> rsp_data=0x3C, wrapper_out=0xA5; rsp_valid exactly 13 edges after accept.
- IR scan len=4, data=0x5 into a 4-bit IR model -> model IR=0x5; rsp_data=IR capture value (0x1); rsp_valid at k+10; tap_state sequence 9,10,11 observed.
- len=40 (> MAX_LEN) DR scan through a 32-bit loopback chain preloaded with 0xDEADBEEF -> clamped to 32 shifts, rsp_data=0xDEADBEEF.
- op=0 from RTI -> tms=1 for 5 edges, tap_state reaches 0, then RTI; rsp_valid at k+6. Also op=3 and len=0 -> rsp_valid next cycle, rsp_data=0, no state change.
- TRST asserted mid-SHIFT_DR -> tap_state=TLR immediately, no rsp_valid, busy=0; a following DR scan completes correctly.
